// File: rtl/uart_interrupt_arbiter.sv
// uart_interrupt_arbiter
//
// Collects UART event pulses into per-source pending latches. It masks them with
// the interrupt enables and picks the highest-priority pending source; index 1
// wins. It then drives the host interrupt line and the ISR read image.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   frame_err_i         source 1 pulse      parity_err_i   source 2 pulse
//   overrun_i           source 3 pulse      rx_thresh_i    source 4 pulse
//   rx_timeout_i        source 5 pulse      tx_done_i      source 6 pulse
//   cfg_done_i          source 7 pulse
//   int_en_i[6:0]       per-source enable, bit k-1 = source k
//   rx_fifo_empty_i     RX FIFO empty level (feeds RXRDY)
//   iack_i              one-cycle interrupt acknowledge strobe
//   irq_o               interrupt request, active level = IRQ_ACTIVE_LEVEL
//   int_pending_o       any enabled source pending
//   isr_o[7:0]          {RXRDY, FRM, PAR, OVR, INTID[2:0], IACK}
//
// Parameters:
//   ACK_TIMEOUT_CYCLES  cycles in ASSERT without iack before re-arbitrating (0 = never)
//   IRQ_ACTIVE_LEVEL    level driven on irq_o while asserted
//
// Build option:
//   ERR_STICKY_EN       when defined, FRM/PAR/OVR are sticky status bits cleared by
//                       an acknowledge of INTID 1..3; otherwise they decode INTID.

module uart_interrupt_arbiter #(
  parameter int unsigned ACK_TIMEOUT_CYCLES = 0,
  parameter bit          IRQ_ACTIVE_LEVEL   = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       frame_err_i,
  input  logic       parity_err_i,
  input  logic       overrun_i,
  input  logic       rx_thresh_i,
  input  logic       rx_timeout_i,
  input  logic       tx_done_i,
  input  logic       cfg_done_i,
  input  logic [6:0] int_en_i,
  input  logic       rx_fifo_empty_i,
  input  logic       iack_i,
  output logic       irq_o,
  output logic       int_pending_o,
  output logic [7:0] isr_o
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StAssert = 2'd1;
  localparam logic [1:0] StRearm  = 2'd2;

  localparam int unsigned CntW =
      (ACK_TIMEOUT_CYCLES > 0) ? $clog2(ACK_TIMEOUT_CYCLES + 1) : 1;
  // Last ASSERT cycle before the timeout fires; the counter never reaches the limit itself.
  localparam logic [CntW-1:0] CntLast =
      (ACK_TIMEOUT_CYCLES > 0) ? CntW'(ACK_TIMEOUT_CYCLES - 1) : '0;

  logic [1:0]      state_q, state_d;
  logic [6:0]      pend_q, pend_d;
  logic [2:0]      intid_q, intid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            irq_q, irq_d;
  logic            int_pending_q;
  logic            rxrdy_q;

  logic [6:0] events;
  logic [6:0] ack_clr;
  logic [2:0] win_id;
  logic       ack_hit;
  logic [2:0] isr_intid;
  logic [2:0] err_bits;  // {OVR, PAR, FRM}

  assign events = {cfg_done_i, tx_done_i, rx_timeout_i, rx_thresh_i,
                   overrun_i, parity_err_i, frame_err_i};

  // Acknowledge only counts while an interrupt is actually being presented.
  assign ack_hit = (state_q == StAssert) && iack_i;

  // Descending scan so the lowest pending index is the one left standing.
  always_comb begin
    win_id = '0;
    for (int k = 7; k >= 1; k--) begin
      if (pend_q[k-1]) win_id = 3'(k);
    end
  end

  always_comb begin
    ack_clr = '0;
    if (ack_hit && (intid_q != 3'd0)) ack_clr[intid_q - 3'd1] = 1'b1;
  end

  // A new enabled event overrides a same-cycle acknowledge clear; disabling a
  // source drops its pending bit.
  assign pend_d = (events & int_en_i) | (pend_q & int_en_i & ~ack_clr);

  always_comb begin
    state_d = state_q;
    intid_d = intid_q;
    cnt_d   = cnt_q;
    irq_d   = irq_q;
    case (state_q)
      StIdle, StRearm: begin
        cnt_d = '0;
        if (|pend_q) begin
          state_d = StAssert;
          intid_d = win_id;
          irq_d   = 1'b1;
        end else begin
          state_d = StIdle;
          intid_d = '0;
          irq_d   = 1'b0;
        end
      end
      StAssert: begin
        if (ack_hit) begin
          state_d = StIdle;
          intid_d = '0;
          irq_d   = 1'b0;
          cnt_d   = '0;
        end else if (ACK_TIMEOUT_CYCLES > 0) begin
          if (cnt_q == CntLast) begin
            state_d = StRearm;
            irq_d   = 1'b0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        intid_d = '0;
        irq_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= StIdle;
      pend_q        <= '0;
      intid_q       <= '0;
      cnt_q         <= '0;
      irq_q         <= 1'b0;
      int_pending_q <= 1'b0;
      rxrdy_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_q        <= pend_d;
      intid_q       <= intid_d;
      cnt_q         <= cnt_d;
      irq_q         <= irq_d;
      int_pending_q <= |pend_d;  // tracks pend_q exactly
      rxrdy_q       <= ~rx_fifo_empty_i;
    end
  end

  assign isr_intid = (state_q == StAssert) ? intid_q : 3'd0;

`ifdef ERR_STICKY_EN
  logic [2:0] err_q, err_d;
  logic       err_clr;

  assign err_clr = ack_hit && (intid_q inside {3'd1, 3'd2, 3'd3});
  // New error pulses win over the acknowledge clear.
  assign err_d   = {overrun_i, parity_err_i, frame_err_i} | (err_q & {3{~err_clr}});

  always_ff @(posedge clk_i) begin
    if (rst_i) err_q <= '0;
    else       err_q <= err_d;
  end

  assign err_bits = err_q;
`else
  assign err_bits = {isr_intid == 3'd3, isr_intid == 3'd2, isr_intid == 3'd1};
`endif

  assign isr_o         = {rxrdy_q, err_bits[0], err_bits[1], err_bits[2], isr_intid, 1'b0};
  assign irq_o         = irq_q ? IRQ_ACTIVE_LEVEL : ~IRQ_ACTIVE_LEVEL;
  assign int_pending_o = int_pending_q;

endmodule

// File: tb/tb_uart_interrupt_arbiter.sv
module tb_uart_interrupt_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_err, parity_err, overrun, rx_thresh, rx_timeout, tx_done, cfg_done;
  logic [6:0] int_en;
  logic       rx_fifo_empty;
  logic       iack;

  logic       irq_a, pend_a;
  logic [7:0] isr_a;
  logic       irq_b, pend_b;
  logic [7:0] isr_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Default configuration: no timeout, active-high irq.
  uart_interrupt_arbiter #(
    .ACK_TIMEOUT_CYCLES(0),
    .IRQ_ACTIVE_LEVEL  (1'b1)
  ) dut_a (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_err_i    (frame_err),
    .parity_err_i   (parity_err),
    .overrun_i      (overrun),
    .rx_thresh_i    (rx_thresh),
    .rx_timeout_i   (rx_timeout),
    .tx_done_i      (tx_done),
    .cfg_done_i     (cfg_done),
    .int_en_i       (int_en),
    .rx_fifo_empty_i(rx_fifo_empty),
    .iack_i         (iack),
    .irq_o          (irq_a),
    .int_pending_o  (pend_a),
    .isr_o          (isr_a)
  );

  // Timeout of 4 cycles, active-low irq.
  uart_interrupt_arbiter #(
    .ACK_TIMEOUT_CYCLES(4),
    .IRQ_ACTIVE_LEVEL  (1'b0)
  ) dut_b (
    .clk_i          (clk),
    .rst_i          (rst),
    .frame_err_i    (frame_err),
    .parity_err_i   (parity_err),
    .overrun_i      (overrun),
    .rx_thresh_i    (rx_thresh),
    .rx_timeout_i   (rx_timeout),
    .tx_done_i      (tx_done),
    .cfg_done_i     (cfg_done),
    .int_en_i       (int_en),
    .rx_fifo_empty_i(rx_fifo_empty),
    .iack_i         (iack),
    .irq_o          (irq_b),
    .int_pending_o  (pend_b),
    .isr_o          (isr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    {frame_err, parity_err, overrun, rx_thresh, rx_timeout, tx_done, cfg_done} = '0;
    int_en        = 7'h7F;
    rx_fifo_empty = 1'b1;
    iack          = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_irq_a", irq_a, 1'b0);
    chk("rst_pend_a", pend_a, 1'b0);
    chk("rst_isr_a", isr_a, 8'h00);
    chk("rst_irq_b_lowactive", irq_b, 1'b1);

    // Single source latency: pend next edge, irq/INTID the edge after
    rx_thresh = 1'b1;
    step();
    rx_thresh = 1'b0;
    chk("thresh_pend", pend_a, 1'b1);
    chk("thresh_irq_early", irq_a, 1'b0);
    step();
    chk("thresh_irq", irq_a, 1'b1);
    chk("thresh_isr", isr_a, 8'h08);
    step();
    step();
    chk("thresh_irq_hold", irq_a, 1'b1);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("thresh_ack_irq", irq_a, 1'b0);
    chk("thresh_ack_isr", isr_a, 8'h00);
    chk("thresh_ack_pend", pend_a, 1'b0);

    // RXRDY is registered from the FIFO empty level
    rx_fifo_empty = 1'b0;
    step();
    chk("rxrdy_set", isr_a, 8'h80);
    rx_fifo_empty = 1'b1;
    step();
    chk("rxrdy_clr", isr_a, 8'h00);

    // Simultaneous parity + tx_done: parity (2) first, then tx_done (6)
    parity_err = 1'b1;
    tx_done    = 1'b1;
    step();
    parity_err = 1'b0;
    tx_done    = 1'b0;
    step();
    chk("prio_irq", irq_a, 1'b1);
    chk("prio_isr_par", isr_a, 8'h24);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("prio_gap_irq", irq_a, 1'b0);
    chk("prio_gap_isr", isr_a, 8'h00);
    chk("prio_gap_pend", pend_a, 1'b1);
    step();
    chk("prio_second_irq", irq_a, 1'b1);
    chk("prio_second_isr", isr_a, 8'h0C);

    // No preemption: frame error while INTID=6 waits for the acknowledge
    frame_err = 1'b1;
    step();
    frame_err = 1'b0;
    step();
    chk("nopreempt_isr", isr_a, 8'h0C);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("nopreempt_gap", irq_a, 1'b0);
    step();
    chk("nopreempt_frm_irq", irq_a, 1'b1);
    chk("nopreempt_frm_isr", isr_a, 8'h42);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("nopreempt_done_pend", pend_a, 1'b0);

    // All sources disabled: events dropped, late enable does not revive them
    int_en = 7'h00;
    {frame_err, parity_err, overrun, rx_thresh, rx_timeout, tx_done, cfg_done} = '1;
    step();
    {frame_err, parity_err, overrun, rx_thresh, rx_timeout, tx_done, cfg_done} = '0;
    step();
    step();
    chk("dis_irq", irq_a, 1'b0);
    chk("dis_pend", pend_a, 1'b0);
    int_en = 7'h04;
    step();
    step();
    chk("dis_late_en_irq", irq_a, 1'b0);
    chk("dis_late_en_pend", pend_a, 1'b0);

    // Disabling a non-selected source drops its pending bit
    int_en  = 7'h7F;
    tx_done  = 1'b1;
    cfg_done = 1'b1;
    step();
    tx_done  = 1'b0;
    cfg_done = 1'b0;
    step();
    chk("enclr_isr", isr_a, 8'h0C);
    int_en = 7'h3F;
    step();
    chk("enclr_pend_keep", pend_a, 1'b1);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("enclr_pend_gone", pend_a, 1'b0);
    step();
    chk("enclr_no_irq", irq_a, 1'b0);
    int_en = 7'h7F;

    // iack while IDLE is ignored
    rx_timeout = 1'b1;
    step();
    rx_timeout = 1'b0;
    iack       = 1'b1;
    step();
    iack = 1'b0;
    chk("idle_iack_irq", irq_a, 1'b1);
    chk("idle_iack_isr", isr_a, 8'h0A);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("idle_iack_done", pend_a, 1'b0);

    // Set beats acknowledge clear on the same source
    overrun = 1'b1;
    step();
    overrun = 1'b0;
    step();
    chk("coll_isr", isr_a, 8'h16);
    iack    = 1'b1;
    overrun = 1'b1;
    step();
    iack    = 1'b0;
    overrun = 1'b0;
    chk("coll_gap_irq", irq_a, 1'b0);
    chk("coll_gap_pend", pend_a, 1'b1);
    step();
    chk("coll_reassert_irq", irq_a, 1'b1);
    chk("coll_reassert_isr", isr_a, 8'h16);
    iack = 1'b1;
    step();
    iack = 1'b0;
    chk("coll_done_pend", pend_a, 1'b0);

    // Timeout re-arm on dut_b (active-low irq): 4 high, 1 low, repeat
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("to_rst_irq_b", irq_b, 1'b1);
    cfg_done = 1'b1;
    step();
    cfg_done = 1'b0;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("to_irq_b_c%0d", i), irq_b, ((i % 5) == 4) ? 1'b1 : 1'b0);
      chk($sformatf("to_isr_b_c%0d", i), isr_b, ((i % 5) == 4) ? 8'h00 : 8'h0E);
      step();
    end
    chk("no_to_irq_a", irq_a, 1'b1);
    chk("no_to_isr_a", isr_a, 8'h0E);

    // Higher-priority arrival wins after the re-arm cycle
    frame_err = 1'b1;
    step();
    frame_err = 1'b0;
    step();
    step();
    step();
    chk("rearm_low_irq_b", irq_b, 1'b1);
    step();
    chk("rearm_win_irq_b", irq_b, 1'b0);
    chk("rearm_win_isr_b", isr_b, 8'h42);

    // Mid-operation reset drops everything
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_irq_a", irq_a, 1'b0);
    chk("midrst_pend_a", pend_a, 1'b0);
    chk("midrst_isr_b", isr_b, 8'h00);
    step();
    chk("midrst_stay_a", irq_a, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_interrupt_arbiter.md
Name: uart_interrupt_arbiter

Overview:
- Collects UART event pulses from the RX/TX datapaths and the configuration handshake into per-source pending latches.
- Masks each source with the interrupt-enable field and selects the highest-priority pending source.
- Drives the host interrupt line and the ISR read image (RXRDY/FRM/PAR/OVR/INTID/IACK layout).
- Sits between the datapath event sources and the register bank; consumes the IACK write strobe from the ISR.

Parameters:
- ACK_TIMEOUT_CYCLES, 0, cycles to wait for IACK before re-triggering irq_o; 0 disables the timeout.
- IRQ_ACTIVE_LEVEL, 1, logic level of irq_o when asserted.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- frame_err_i  in  1  RX frame error pulse (source 1)
- parity_err_i  in  1  RX parity error pulse (source 2)
- overrun_i  in  1  RX overrun pulse (source 3)
- rx_thresh_i  in  1  RX FIFO reached threshold pulse (source 4)
- rx_timeout_i  in  1  RX idle-timeout-with-data pulse (source 5)
- tx_done_i  in  1  TX FIFO drained pulse (source 6)
- cfg_done_i  in  1  configuration handshake done pulse (source 7)
- int_en_i  in  7  per-source enable, bit k-1 = source k
- rx_fifo_empty_i  in  1  RX FIFO empty level
- iack_i  in  1  one-cycle IACK write strobe
- irq_o  out  1  interrupt request to host
- int_pending_o  out  1  any enabled source pending (CTR.INTPEND)
- isr_o  out  8  {RXRDY, FRM, PAR, OVR, INTID[2:0], IACK}

Behaviour:
- Reset: state IDLE, pend[7:1]=0, INTID=0, timeout counter=0, irq_o=!IRQ_ACTIVE_LEVEL, int_pending_o=0, isr_o=8'h00.
- Capture: pend[k] is set the cycle after an event pulse when int_en_i[k-1]=1; events on disabled sources are dropped.
- Enable clear: int_en_i[k-1]=0 clears pend[k] on the next edge.
- Set/clear collision: a set event in the same cycle as a clear by IACK wins; pend stays 1.
- Priority: lowest index wins (1 highest … 7 lowest). INTID encoding equals the source index; 3'b000 means none.
- FSM states: IDLE, ASSERT, REARM.
  - IDLE: if any pend=1, latch INTID = highest-priority pending index and go to ASSERT. irq_o asserts on that same edge.
  - ASSERT: irq_o asserted; INTID frozen, with no preemption by higher-priority arrivals.
    - On iack_i: clear pend[INTID], deassert irq_o and go to IDLE on the next edge. Minimum one-cycle irq_o low gap between interrupts.
    - With ACK_TIMEOUT_CYCLES>0, the counter increments every ASSERT cycle. On reaching ACK_TIMEOUT_CYCLES (no iack): go to REARM, deassert irq_o and zero the counter.
  - REARM: one cycle with irq_o low, then re-arbitrate as in IDLE; a higher-priority source may now win.
- iack_i in IDLE or REARM: ignored, no pend change.
- Latency: event at edge N → pend at N+1 → irq_o and INTID at N+2 when starting from IDLE.
- int_pending_o = OR(pend), registered.
- isr_o.RXRDY = !rx_fifo_empty_i, registered.
- isr_o.INTID = latched INTID in ASSERT, else 0. isr_o.IACK always reads 0.
- isr_o FRM/PAR/OVR: see Optional Feature.
- Reset mid-operation: all state returns to reset values at the next edge; pending events are lost.
- Timeout counter width is clog2(ACK_TIMEOUT_CYCLES+1), minimum 1 bit; it cannot wrap because it is cleared on reaching the limit.

Optional Feature:
- Macro: ERR_STICKY_EN
- Defined: FRM/PAR/OVR in isr_o are sticky status bits, set the cycle after their error pulse regardless of int_en_i. All three clear together on iack_i when INTID is 1, 2 or 3; a simultaneous new error keeps its bit set.
- Undefined: FRM/PAR/OVR are decoded only from the current INTID (exactly one set when INTID is 1/2/3, else all 0); no extra flops.

Test Plan:
- Reset, int_en_i=7'h7F, pulse rx_thresh_i at cycle 5 → pend[4]=1 at 6; irq_o=1 and isr_o INTID=3'b100 at 7. iack_i at 10 → irq_o=0 and INTID=0 at 11.
- Pulse tx_done_i and parity_err_i in the same cycle → INTID=2 first; after iack, one low cycle, then INTID=6.
- In ASSERT with INTID=6, pulse frame_err_i → INTID stays 6 until iack; INTID=1 follows after the one-cycle gap.
- int_en_i=7'h00, pulse every source → irq_o stays deasserted, int_pending_o=0. Set enable for source 3 with pend previously dropped → still no irq.
- ACK_TIMEOUT_CYCLES=4, pulse cfg_done_i, never ack → irq_o high 4 cycles, low 1, high again with INTID=7. Repeats every 5 cycles.
- iack_i coincident with a new overrun_i while INTID=3 → pend[3] stays 1 and irq_o reasserts with INTID=3 after the one-cycle gap. With ERR_STICKY_EN, OVR remains 1.
